// File: rtl/imem_loader_if.sv
// Byte-stream / instruction-memory write bundle for imem_loader.
// master: loader side (takes bytes, drives memory writes); slave: source/memory side.
interface imem_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;

    modport master (
        input  byte_valid, byte_data,
        output byte_ready, mem_we, mem_waddr, mem_wdata
    );

    modport slave (
        output byte_valid, byte_data,
        input  byte_ready, mem_we, mem_waddr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Loads the instruction memory from a byte stream, little-endian words at 0,4,8,...
// Ports: clk, reset (sync, active-high), start/word_count (load request), bus
// (byte handshake + memory write), busy/done/error/cpu_hold status (all registered).
module imem_loader #(
    parameter int WORDS = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] word_count,
    imem_loader_if.master    bus,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             cpu_hold
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] word_idx, word_idx_n;
    logic [CNT_W-1:0] count_lat, count_n;
    logic [1:0]       byte_idx, byte_idx_n;
    // Only the low three bytes are stored; the fourth goes straight to wdata.
    logic [23:0]      asm_q, asm_n;
    logic             ready_q, ready_n;
    logic             we_q, we_n;
    logic [31:0]      waddr_q, waddr_n;
    logic [31:0]      wdata_q, wdata_n;
    logic             busy_q, busy_n;
    logic             done_q, done_n;
    logic             error_q, error_n;
    logic             hold_q, hold_n;
    logic             count_ok;
    logic             last_word;

    assign count_ok  = (word_count != '0) &&
                       (word_count <= CNT_W'(WORDS));
    assign last_word = (word_idx == count_lat - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            word_idx  <= '0;
            count_lat <= '0;
            byte_idx  <= '0;
            asm_q     <= '0;
            ready_q   <= 1'b0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            hold_q    <= 1'b0;
        end else begin
            state     <= state_n;
            word_idx  <= word_idx_n;
            count_lat <= count_n;
            byte_idx  <= byte_idx_n;
            asm_q     <= asm_n;
            ready_q   <= ready_n;
            we_q      <= we_n;
            waddr_q   <= waddr_n;
            wdata_q   <= wdata_n;
            busy_q    <= busy_n;
            done_q    <= done_n;
            error_q   <= error_n;
            hold_q    <= hold_n;
        end
    end

    always_comb begin
        state_n    = state;
        word_idx_n = word_idx;
        count_n    = count_lat;
        byte_idx_n = byte_idx;
        asm_n      = asm_q;
        ready_n    = 1'b0;
        we_n       = 1'b0;
        waddr_n    = waddr_q;
        wdata_n    = wdata_q;
        busy_n     = busy_q;
        done_n     = done_q;
        error_n    = error_q;
        hold_n     = hold_q;
        unique case (state)
            IDLE: begin
                if (start) begin
                    done_n = 1'b0;
                    if (count_ok) begin
                        state_n    = COLLECT;
                        count_n    = word_count;
                        word_idx_n = '0;
                        byte_idx_n = '0;
                        error_n    = 1'b0;
                        busy_n     = 1'b1;
                        hold_n     = 1'b1;
                        ready_n    = 1'b1;
                    end else begin
                        error_n = 1'b1;
                    end
                end
            end
            COLLECT: begin
                ready_n = 1'b1;
                if (bus.byte_valid && ready_q) begin
                    byte_idx_n = byte_idx + 2'd1;
                    unique case (byte_idx)
                        2'd0: asm_n[7:0]   = bus.byte_data;
                        2'd1: asm_n[15:8]  = bus.byte_data;
                        2'd2: asm_n[23:16] = bus.byte_data;
                        2'd3: begin
                            state_n = WRITE;
                            ready_n = 1'b0;
                            we_n    = 1'b1;
                            waddr_n = {{(30-CNT_W){1'b0}},
                                       word_idx, 2'b00};
                            wdata_n = {bus.byte_data, asm_q};
                        end
                        default: ;
                    endcase
                end
            end
            WRITE: begin
                if (last_word) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    hold_n  = 1'b0;
                    done_n  = 1'b1;
                end else begin
                    state_n    = COLLECT;
                    word_idx_n = word_idx + CNT_W'(1);
                    byte_idx_n = '0;
                    ready_n    = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.byte_ready = ready_q;
    assign bus.mem_we     = we_q;
    assign bus.mem_waddr  = waddr_q;
    assign bus.mem_wdata  = wdata_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign cpu_hold       = hold_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: single/multi-word loads, bad counts,
// mid-load reset and a full 32-word load with a spurious start.
module tb_imem_loader;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [5:0] word_count = '0;
    logic       busy, done, error, cpu_hold;

    imem_loader_if bus_if ();

    imem_loader #(.WORDS(32), .CNT_W(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .word_count (word_count),
        .bus        (bus_if),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .cpu_hold   (cpu_hold)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          we_cnt = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    logic        mon = 1'b0;
    logic        hold_lost = 1'b0;

    always @(negedge clk) begin
        if (bus_if.mem_we === 1'b1) begin
            we_cnt++;
            wa.push_back(bus_if.mem_waddr);
            wd.push_back(bus_if.mem_wdata);
        end
        if (mon && !(busy === 1'b1 && cpu_hold === 1'b1))
            hold_lost = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        we_cnt = 0;
        wa.delete();
        wd.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [5:0] cnt);
        start = 1'b1;
        word_count = cnt;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        bus_if.byte_valid = 1'b0;
        repeat (gap) tick();
        bus_if.byte_valid = 1'b1;
        bus_if.byte_data = b;
        n = 0;
        while (bus_if.byte_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            n_cmp++;
            n_err++;
            $error("FAIL byte_timeout: observed ready=%b expected 1",
                   bus_if.byte_ready);
        end
        tick();
        bus_if.byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int k = 0; k < 4; k++)
            send_byte(w[8*k +: 8], $urandom_range(0, maxgap));
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_ready"}, 32'(bus_if.byte_ready), 32'd0);
        check({tag, "_we"}, 32'(bus_if.mem_we), 32'd0);
        check({tag, "_waddr"}, bus_if.mem_waddr, 32'd0);
        check({tag, "_wdata"}, bus_if.mem_wdata, 32'd0);
        check({tag, "_stat"}, {28'd0, busy, done, error, cpu_hold}, 32'd0);
    endtask

    logic [31:0] w3[3];
    logic [31:0] d;

    initial begin
        bus_if.byte_valid = 1'b0;
        bus_if.byte_data = '0;
        w3[0] = 32'h00700113;
        w3[1] = 32'h00202223;
        w3[2] = 32'h00402083;

        // 1. reset
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_idle_zero("reset");

        // 2. single word, back-to-back bytes
        clear_log();
        do_start(6'd1);
        check("t2_busy", {29'd0, busy, cpu_hold, bus_if.byte_ready}, 32'd7);
        send_word(32'h00700113, 0);
        check("t2_we", 32'(bus_if.mem_we), 32'd1);
        check("t2_waddr", bus_if.mem_waddr, 32'h0);
        check("t2_wdata", bus_if.mem_wdata, 32'h00700113);
        check("t2_ready_wr", 32'(bus_if.byte_ready), 32'd0);
        tick();
        check("t2_done", {29'd0, done, busy, cpu_hold}, 32'd4);
        check("t2_we_off", 32'(bus_if.mem_we), 32'd0);
        check("t2_wdata_hold", bus_if.mem_wdata, 32'h00700113);
        check("t2_cnt", 32'(we_cnt), 32'd1);

        // 3. three words with random gaps
        clear_log();
        hold_lost = 1'b0;
        do_start(6'd3);
        mon = 1'b1;
        for (int w = 0; w < 3; w++)
            send_word(w3[w], 3);
        mon = 1'b0;
        tick();
        check("t3_done", {30'd0, done, busy}, 32'd2);
        check("t3_hold", 32'(hold_lost), 32'd0);
        check("t3_cnt", 32'(we_cnt), 32'd3);
        for (int w = 0; w < 3; w++) begin
            check($sformatf("t3_addr%0d", w), wa[w], 32'(w * 4));
            check($sformatf("t3_data%0d", w), wd[w], w3[w]);
        end

        // 4. bad counts, then valid start clears error
        clear_log();
        do_start(6'd0);
        check("t4_err0", {29'd0, error, done, busy}, 32'd4);
        check("t4_rdy0", 32'(bus_if.byte_ready), 32'd0);
        do_start(6'd33);
        check("t4_err33", {29'd0, error, done, busy}, 32'd4);
        tick();
        check("t4_rdy33", 32'(bus_if.byte_ready), 32'd0);
        check("t4_nowe", 32'(we_cnt), 32'd0);
        do_start(6'd2);
        check("t4_clr", {30'd0, error, busy}, 32'd1);

        // 5. reset after word 0 and 2 bytes of word 1
        send_word(32'h00700113, 1);
        send_byte(8'h23, 0);
        send_byte(8'h22, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle_zero("t5_rst");
        repeat (6) tick();
        check("t5_cnt", 32'(we_cnt), 32'd1);
        do_start(6'd1);
        send_word(32'h00202223, 2);
        tick();
        check("t5_cnt2", 32'(we_cnt), 32'd2);
        check("t5_addr", wa[1], 32'h0);
        check("t5_data", wd[1], 32'h00202223);
        check("t5_done", 32'(done), 32'd1);

        // 6. full 32-word load with start pulsed mid-load
        clear_log();
        hold_lost = 1'b0;
        do_start(6'd32);
        mon = 1'b1;
        for (int i = 0; i < 32; i++) begin
            d = {8'(i), 8'hA5, 8'(i + 1), 8'h13};
            send_word(d, (i % 4 == 0) ? 2 : 0);
            if (i == 10) do_start(6'd1);
        end
        mon = 1'b0;
        tick();
        check("t6_cnt", 32'(we_cnt), 32'd32);
        check("t6_done", {30'd0, done, busy}, 32'd2);
        check("t6_hold", 32'(hold_lost), 32'd0);
        check("t6_last", bus_if.mem_waddr, 32'h7C);
        for (int i = 0; i < 32 && i < we_cnt; i++) begin
            d = {8'(i), 8'hA5, 8'(i + 1), 8'h13};
            check($sformatf("t6_addr%0d", i), wa[i], 32'(i * 4));
            check($sformatf("t6_data%0d", i), wd[i], d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream writer that fills the processor's 32-word instruction memory, replacing the hard-coded program image loaded at reset.
- Accepts bytes over a valid/ready handshake and assembles them into little-endian 32-bit RISC-V instruction words.
- Issues one single-cycle write per word, at byte addresses 0, 4, 8, …, matching the fetch side's address/4 word indexing.
- Holds the CPU (cpu_hold) while a load is in progress.

Parameters:
- WORDS, 32, instruction memory depth in words.
- CNT_W, 6, width of word_count (must hold WORDS).

Ports:
- clk  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- start  input  1  begin a load; sampled only in IDLE.
- word_count  input  CNT_W  words to load; latched on accepted start.
- byte_valid  input  1  byte_data is valid.
- byte_data  input  8  next program byte, LSB first within each word.
- byte_ready  output  1  loader can accept a byte this cycle.
- mem_we  output  1  instruction memory write strobe, one cycle per word.
- mem_waddr  output  32  byte address of the word being written (word_idx*4).
- mem_wdata  output  32  assembled instruction word.
- busy  output  1  load in progress.
- done  output  1  last load completed; sticky.
- error  output  1  last start was rejected; sticky.
- cpu_hold  output  1  keep CPU stalled while loading.

Behaviour:
- All outputs are registered, Moore-style from state. State registers: state, word_idx, byte_idx (2b), shift register, count_lat.
- Reset values:
  - state = IDLE.
  - byte_ready, mem_we, busy, done, error, cpu_hold = 0.
  - mem_waddr, mem_wdata = 0.
  - word_idx, byte_idx = 0.
- States:
  - IDLE, COLLECT, WRITE.
  - "DONE" is not a state; it is IDLE with done=1.
- IDLE:
  - start=1 with 1 ≤ word_count ≤ WORDS: latch count, clear word_idx/byte_idx, done=0, error=0, go to COLLECT. busy, cpu_hold and byte_ready are 1 from the next cycle.
  - start=1 with word_count=0 or >WORDS: error=1, done=0, stay in IDLE, no write.
- COLLECT:
  - byte_ready=1.
  - A byte is accepted on an edge where byte_valid & byte_ready. It is placed at bits [8*byte_idx+7 : 8*byte_idx], then byte_idx increments.
  - byte_valid low causes a stall with no state change; gaps of any length are legal.
  - The 4th accepted byte moves the state to WRITE. In the following cycle: byte_ready=0, mem_we=1, mem_waddr=word_idx*4, mem_wdata=assembled word.
- WRITE:
  - Lasts exactly one cycle. mem_we drops after it; mem_waddr and mem_wdata hold their last values.
  - If word_idx == count_lat-1: go to IDLE. Next cycle: done=1, busy=0, cpu_hold=0, byte_ready=0.
  - Otherwise: word_idx+1, byte_idx=0, return to COLLECT (byte_ready=1 next cycle).
- Latency:
  - 4th byte accepted at edge N: mem_we is high in cycle N..N+1.
  - Minimum 5 cycles per word at full byte rate.
- start while busy is ignored. word_count changes after latch have no effect.
- Boundaries:
  - Maximum address is (WORDS-1)*4 = 124; no wrap is possible since count ≤ WORDS.
  - byte_valid in IDLE or WRITE is not accepted (byte_ready=0); the byte is not consumed.
- Reset mid-operation:
  - Returns to IDLE with reset values; the partial word is discarded and no write is issued.
  - Words already written remain in memory (memory is not cleared here).
- mem_we and mem_wdata are never X after reset.

Test Plan:
1. Reset: assert reset 2 cycles → all outputs 0, byte_ready=0, state IDLE.
2. Single word: start with word_count=1, then bytes 0x13,0x01,0x70,0x00 back-to-back → exactly one mem_we pulse with addr 0x0, data 0x00700113 (addi x2,x0,7). Next cycle done=1, busy=0, cpu_hold=0.
3. Three words with random byte_valid gaps, words 0x00700113, 0x00202223, 0x00402083 → writes at addr 0x0, 0x4, 0x8 in order with correct data. busy and cpu_hold stay 1 throughout; exactly 3 mem_we pulses.
4. Bad count: start with word_count=0, then start with word_count=33 → error=1 both times, no mem_we, byte_ready stays 0. A following valid start clears error.
5. Reset after 2 bytes of word 1 (word 0 already written) → no further mem_we, all outputs 0. A new load of 1 word writes addr 0x0.
6. Full load of 32 words, with start pulsed mid-load → start ignored. Last write at addr 0x7C; 32 mem_we pulses total, then done=1.
